tff_counter_ctrl: RTL and testbench

- Sequencer for a bank of WIDTH T flip-flops (one tff_cell per bit).
- Accepts load / count-up / count-down commands over a valid/ready handshake and generates the per-bit toggle vector every cycle.
- Counts to a programmed terminal value, then pulses done.
- Used wherever the team builds programmable counters from toggle cells.

---
 rtl/tff_ctrl_pkg.sv | 21 ++
 rtl/tff_counter_ctrl_cell.sv | 24 ++
 rtl/tff_counter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tff_counter_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_ctrl_pkg.sv
// Shared encodings for the T-cell counter controller: command opcodes and FSM states.
package tff_ctrl_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN_UP   = 3'd2,
    ST_RUN_DOWN = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_LOAD) || (s == ST_RUN_UP) || (s == ST_RUN_DOWN);
  endfunction

endpackage

// File: rtl/tff_counter_ctrl_cell.sv
// Single T flip-flop: inverts its state on every rising edge where i_t is high.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic i_t,
  output logic o_q
);

  logic r_q;

  // toggle register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (i_t) begin
      r_q <= ~r_q;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Command sequencer for a bank of WIDTH T-cells (load / count up / count down to a terminal value).
// Optional per-toggle prescaler is enabled by defining TFF_CTRL_PRESCALE_EN.
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             stop,
`ifdef TFF_CTRL_PRESCALE_EN
  input  logic [3:0]       prescale,
`endif
  output logic [WIDTH-1:0] count_q,
  output logic [WIDTH-1:0] tog,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_up_tog;
  logic [WIDTH-1:0] w_dn_tog;
  logic [WIDTH-1:0] w_q;
  logic             w_accept;
  logic             w_tick;
  logic             w_run;

  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_run     = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DOWN);

`ifdef TFF_CTRL_PRESCALE_EN
  logic [3:0] r_prescale;
  logic [3:0] r_pre_cnt;

  assign w_tick = (r_pre_cnt == r_prescale);

  // prescale divider: restarts on accept, stop, reset and after each toggle cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale <= 4'd0;
      r_pre_cnt  <= 4'd0;
    end else if (w_accept) begin
      r_prescale <= prescale;
      r_pre_cnt  <= 4'd0;
    end else if (w_run && !stop && !w_tick) begin
      r_pre_cnt  <= r_pre_cnt + 4'd1;
    end else begin
      r_pre_cnt  <= 4'd0;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // ripple-free synchronous count toggles: bit i flips when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    w_up_tog    = '0;
    w_dn_tog    = '0;
    w_up_tog[0] = 1'b1;
    w_dn_tog[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_up_tog[i] = w_up_tog[i-1] & w_q[i-1];
      w_dn_tog[i] = w_dn_tog[i-1] & ~w_q[i-1];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // target captured with every accepted command
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target <= '0;
    end else if (w_accept) begin
      r_target <= cmd_data;
    end else begin
      r_target <= r_target;
    end
  end

  // next-state and toggle vector; stop wins over any pending toggle including the final one
  always_comb begin
    w_next = r_state;
    w_tog  = '0;
    if (rst) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (cmd_op)
              OP_LOAD: w_next = ST_LOAD;
              OP_UP:   w_next = (w_q == cmd_data) ? ST_DONE : ST_RUN_UP;
              OP_DOWN: w_next = (w_q == cmd_data) ? ST_DONE : ST_RUN_DOWN;
              default: w_next = ST_IDLE;
            endcase
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (stop) begin
            w_next = ST_IDLE;
          end else begin
            w_tog  = w_q ^ r_target;
            w_next = ST_DONE;
          end
        end
        ST_RUN_UP: begin
          if (stop) begin
            w_next = ST_IDLE;
          end else if (w_tick) begin
            w_tog  = w_up_tog;
            w_next = ((w_q + WIDTH'(1'b1)) == r_target) ? ST_DONE : ST_RUN_UP;
          end else begin
            w_next = ST_RUN_UP;
          end
        end
        ST_RUN_DOWN: begin
          if (stop) begin
            w_next = ST_IDLE;
          end else if (w_tick) begin
            w_tog  = w_dn_tog;
            w_next = ((w_q - WIDTH'(1'b1)) == r_target) ? ST_DONE : ST_RUN_DOWN;
          end else begin
            w_next = ST_RUN_DOWN;
          end
        end
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .i_t (w_tog[g]),
      .o_q (w_q[g])
    );
  end

  assign count_q = w_q;
  assign tog     = w_tog;
  assign busy    = is_busy(r_state);
  assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Directed self-checking bench for tff_counter_ctrl (prescale case runs when TFF_CTRL_PRESCALE_EN is defined).
module tb_tff_counter_ctrl;

  localparam logic [1:0] C_NOP  = 2'b00;
  localparam logic [1:0] C_UP   = 2'b01;
  localparam logic [1:0] C_DOWN = 2'b10;
  localparam logic [1:0] C_LOAD = 2'b11;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       stop;
  logic [7:0] count_q;
  logic [7:0] tog;
  logic       busy;
  logic       done;
`ifdef TFF_CTRL_PRESCALE_EN
  logic [3:0] prescale;
`endif

  int n_checks = 0;
  int n_errors = 0;

  tff_counter_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .stop      (stop),
`ifdef TFF_CTRL_PRESCALE_EN
    .prescale  (prescale),
`endif
    .count_q   (count_q),
    .tog       (tog),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
  endtask

  task automatic do_load(input logic [7:0] val, input logic [7:0] prev);
    send(C_LOAD, val);
    check_eq("load_tog", tog, prev ^ val);
    check_eq("load_busy", 8'(busy), 8'd1);
    step();
    check_eq("load_q", count_q, val);
    check_eq("load_done", 8'(done), 8'd1);
    check_eq("load_busy_done", 8'(busy), 8'd0);
    check_eq("load_ready_done", 8'(cmd_ready), 8'd0);
    step();
    check_eq("load_done_clr", 8'(done), 8'd0);
    check_eq("load_ready_idle", 8'(cmd_ready), 8'd1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] target,
                         input logic [7:0] start, input int exp_cycles);
    logic [7:0] cur;
    logic [7:0] nxt;
    int n;
    send(op, target);
    cur = start;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      check_eq("run_q", count_q, cur);
      nxt = (op == C_UP) ? cur + 8'd1 : cur - 8'd1;
      check_eq("run_tog", tog, cur ^ nxt);
      cur = nxt;
      step();
      n++;
    end
    check_eq("run_cycles", 8'(n), 8'(exp_cycles));
    check_eq("run_done", 8'(done), 8'd1);
    check_eq("run_final_q", count_q, target);
    check_eq("run_done_tog", tog, 8'h00);
    step();
    check_eq("run_done_clr", 8'(done), 8'd0);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = C_NOP;
    cmd_data = 8'h00;
    stop = 1'b0;
`ifdef TFF_CTRL_PRESCALE_EN
    prescale = 4'd0;
`endif
    #1;
    check_eq("rst_ready0", 8'(cmd_ready), 8'd0);
    step();
    step();
    check_eq("rst_q", count_q, 8'h00);
    check_eq("rst_busy", 8'(busy), 8'd0);
    check_eq("rst_done", 8'(done), 8'd0);
    check_eq("rst_tog", tog, 8'h00);
    check_eq("rst_ready1", 8'(cmd_ready), 8'd0);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", 8'(cmd_ready), 8'd1);

    do_load(8'hA5, 8'h00);
    do_load(8'h03, 8'hA5);
    run_cmd(C_UP, 8'h06, 8'h03, 3);
    do_load(8'hFE, 8'h06);
    run_cmd(C_UP, 8'h01, 8'hFE, 3);
    run_cmd(C_DOWN, 8'hFE, 8'h01, 3);

    // stop after four toggles of a 0 -> 10 run
    do_load(8'h00, 8'hFE);
    send(C_UP, 8'h0A);
    repeat (4) step();
    check_eq("stop_pre_q", count_q, 8'h04);
    check_eq("stop_pre_busy", 8'(busy), 8'd1);
    stop = 1'b1;
    #1;
    check_eq("stop_tog", tog, 8'h00);
    step();
    stop = 1'b0;
    check_eq("stop_q", count_q, 8'h04);
    check_eq("stop_busy", 8'(busy), 8'd0);
    check_eq("stop_done", 8'(done), 8'd0);
    check_eq("stop_ready", 8'(cmd_ready), 8'd1);
    step();
    check_eq("stop_no_done", 8'(done), 8'd0);

    // reset mid-run at count 7
    send(C_UP, 8'h0A);
    repeat (3) step();
    check_eq("mrst_pre_q", count_q, 8'h07);
    rst = 1'b1;
    #1;
    check_eq("mrst_ready", 8'(cmd_ready), 8'd0);
    step();
    rst = 1'b0;
    check_eq("mrst_q", count_q, 8'h00);
    check_eq("mrst_busy", 8'(busy), 8'd0);
    check_eq("mrst_done", 8'(done), 8'd0);
    step();
    check_eq("mrst_no_done", 8'(done), 8'd0);

    // count to current value, then a held command waits through DONE
    cmd_valid = 1'b1;
    cmd_op    = C_UP;
    cmd_data  = 8'h00;
    step();
    check_eq("imm_done", 8'(done), 8'd1);
    check_eq("imm_busy", 8'(busy), 8'd0);
    check_eq("imm_tog", tog, 8'h00);
    check_eq("imm_ready", 8'(cmd_ready), 8'd0);
    cmd_op    = C_LOAD;
    cmd_data  = 8'h5A;
    step();
    check_eq("held_idle_ready", 8'(cmd_ready), 8'd1);
    check_eq("held_idle_busy", 8'(busy), 8'd0);
    check_eq("held_idle_q", count_q, 8'h00);
    check_eq("held_idle_done", 8'(done), 8'd0);
    step();
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
    check_eq("held_load_busy", 8'(busy), 8'd1);
    check_eq("held_load_tog", tog, 8'h5A);
    step();
    check_eq("held_load_q", count_q, 8'h5A);
    check_eq("held_load_done", 8'(done), 8'd1);
    step();

    // NOP is consumed without effect
    send(C_NOP, 8'h77);
    check_eq("nop_busy", 8'(busy), 8'd0);
    check_eq("nop_ready", 8'(cmd_ready), 8'd1);
    check_eq("nop_q", count_q, 8'h5A);
    step();
    check_eq("nop_done", 8'(done), 8'd0);

    // stop during LOAD
    send(C_LOAD, 8'hFF);
    stop = 1'b1;
    #1;
    check_eq("lstop_tog", tog, 8'h00);
    step();
    stop = 1'b0;
    check_eq("lstop_q", count_q, 8'h5A);
    check_eq("lstop_done", 8'(done), 8'd0);
    check_eq("lstop_busy", 8'(busy), 8'd0);

    // stop coincident with the final toggle
    send(C_UP, 8'h5B);
    check_eq("fstop_busy", 8'(busy), 8'd1);
    stop = 1'b1;
    #1;
    check_eq("fstop_tog", tog, 8'h00);
    step();
    stop = 1'b0;
    check_eq("fstop_q", count_q, 8'h5A);
    check_eq("fstop_done", 8'(done), 8'd0);
    check_eq("fstop_ready", 8'(cmd_ready), 8'd1);

    // stop has no effect in DONE
    send(C_DOWN, 8'h5A);
    stop = 1'b1;
    #1;
    check_eq("dstop_done", 8'(done), 8'd1);
    step();
    stop = 1'b0;
    check_eq("dstop_ready", 8'(cmd_ready), 8'd1);
    check_eq("dstop_q", count_q, 8'h5A);

`ifdef TFF_CTRL_PRESCALE_EN
    begin
      int n;
      do_load(8'h00, 8'h5A);
      prescale = 4'd2;
      send(C_UP, 8'h03);
      prescale = 4'd0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        check_eq("pre_tog_active", 8'(tog != 8'h00), 8'((n % 3) == 2));
        step();
        n++;
      end
      check_eq("pre_cycles", 8'(n), 8'd9);
      check_eq("pre_done", 8'(done), 8'd1);
      check_eq("pre_q", count_q, 8'h03);
      step();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
